dot_scan_ctrl: RTL and testbench
================================

Name: dot_scan_ctrl

Overview:
Row-scan sequencer for the 8x8 dot-matrix display path. Holds a double-buffered 64-bit frame and steps a 3-bit row select `cs` through rows 0..7. It drives the frame and `cs` into the downstream registered row selector, which has 1-cycle latency. It generates the one-hot row drive aligned to that selector output, with blanking between rows to suppress ghosting. New frames are loaded through a shadow buffer and swapped only at frame boundaries.

Parameters:
DIV, 16, cycles per row display slot (DISPLAY state length); legal range 2..65535.
BLANK, 4, cycles of all-rows-off between rows (BLANK state length); legal range 1..65535.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
en  input  1  scan enable; 0 forces IDLE
load  input  1  1-cycle strobe: capture d_in into shadow buffer
d_in  input  64  new frame; row r occupies bits [8r+7:8r]
load_ack  output  1  1-cycle pulse, cycle after load is sampled
frame  output  64  active frame buffer, to row selector d
cs  output  3  current row index, to row selector cs
row  output  8  one-hot row drive (active high); 0 when blanked/idle
blank  output  1  1 when row==0 (IDLE, BLANK, first DISPLAY cycle)
frame_done  output  1  1-cycle pulse at each completed 8-row frame

Behaviour:
- Reset (async, rst_n=0) clears all state:
  - outputs: load_ack=0, frame=0, cs=0, row=0, blank=1, frame_done=0.
  - internal: shadow=0, pending=0, counter=0, state=IDLE.
- All outputs are registered.
- States: IDLE, DISPLAY, BLANK. The 16-bit counter is cleared on every state entry.
- IDLE:
  - row=0, cs=0.
  - If pending=1: frame<=shadow, pending<=0, even when en=0.
  - en=1 sampled -> DISPLAY from the next cycle, cs=0.
- DISPLAY:
  - Lasts exactly DIV cycles.
  - Cycle 0: row=0. This covers the selector's 1-cycle latency.
  - Cycles 1..DIV-1: row=1<<cs.
  - After cycle DIV-1 -> BLANK.
- BLANK:
  - Lasts exactly BLANK cycles, row=0.
  - Then -> DISPLAY with cs<=cs+1, wrapping 7->0.
- Row period is DIV+BLANK cycles; frame period is 8*(DIV+BLANK) cycles.
- Frame boundary, on the BLANK->DISPLAY transition with old cs=7:
  - frame_done=1 for the first DISPLAY cycle of the new row 0.
  - In that same cycle, if pending=1: frame<=shadow, pending<=0.
  - frame never changes at any other time while scanning.
- Load:
  - load=1 sampled in any state: shadow<=d_in, pending<=1, load_ack=1 on the next cycle.
  - Back-to-back loads: the last one wins; each produces its own load_ack.
  - Load in the same cycle as a swap: the swap uses the old shadow. The new data stays in shadow with pending=1 for the next boundary.
- en=0 sampled in DISPLAY/BLANK:
  - Next cycle: IDLE, row=0, cs=0, counter=0, no frame_done pulse.
  - A pending swap then occurs per the IDLE rule.
- Re-enable always restarts at row 0.
- Reset mid-scan returns to the reset state immediately; shadow and pending are lost.
- blank = (row==0), registered alongside row.

Test Plan:
- Reset with DIV=4, BLANK=2: assert rst_n=0 mid-scan -> immediately row=0, cs=0, frame=0, blank=1; release, en=0 -> stays IDLE.
- Basic scan:
  - Stimulus: load d_in=64'h8040201008040201 in IDLE, then en=1.
  - Required: load_ack pulses 1 cycle after load, and frame=d_in before the first DISPLAY cycle.
  - Required: row sequence per 6-cycle period is 00,01,01,01,00,00, then 00,02,02,02,00,00, and so on.
  - Required: cs increments every 6 cycles and frame_done pulses every 48 cycles.
- Deferred swap:
  - Stimulus: load 64'hFFFF... during row 3.
  - Required: frame stays unchanged through row 7 and becomes all-ones exactly in the frame_done cycle.
  - Required: after the swap, pending=0 and no further change occurs.
- Simultaneous load+swap: load A during row 5, then load B in the exact frame_done cycle -> frame=A at that boundary, frame=B at the next boundary, and 2 load_acks are seen.
- en drop: deassert en during BLANK of row 6 -> next cycle IDLE, row=0, cs=0, no frame_done; re-assert -> scan restarts at cs=0.
- Parameter corner DIV=2, BLANK=1: row high exactly 1 cycle of every 3; cs wraps 7->0 every 24 cycles with no skipped or repeated row.

Source files
------------

// File: rtl/dot_scan_ctrl.sv
// rtl/dot_scan_ctrl.sv - 8x8 dot-matrix row-scan sequencer with double-buffered frame
// Row drive is delayed one cycle into each DISPLAY slot to line up with the registered row selector.

module dot_scan_ctrl #(
   parameter int unsigned DIV   = 16,
   parameter int unsigned BLANK = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        load,
   input  logic [63:0] d_in,
   output logic        load_ack,
   output logic [63:0] frame,
   output logic [2:0]  cs,
   output logic [7:0]  row,
   output logic        blank,
   output logic        frame_done
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DISPLAY,
      ST_BLANK
   } state_e;

   localparam logic [15:0] DIV_LAST   = 16'(DIV - 1);
   localparam logic [15:0] BLANK_LAST = 16'(BLANK - 1);

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  cs_q, cs_d;
   logic [63:0] frame_q, frame_d;
   logic [63:0] shadow_q, shadow_d;
   logic        pending_q, pending_d;
   logic        load_ack_q, load_ack_d;
   logic [7:0]  row_q, row_d;
   logic        blank_q, blank_d;
   logic        done_q, done_d;
   logic        swap;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 16'd0;
         cs_q       <= 3'd0;
         frame_q    <= 64'd0;
         shadow_q   <= 64'd0;
         pending_q  <= 1'b0;
         load_ack_q <= 1'b0;
         row_q      <= 8'd0;
         blank_q    <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cs_q       <= cs_d;
         frame_q    <= frame_d;
         shadow_q   <= shadow_d;
         pending_q  <= pending_d;
         load_ack_q <= load_ack_d;
         row_q      <= row_d;
         blank_q    <= blank_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 16'd1;
      cs_d      = cs_q;
      frame_d   = frame_q;
      shadow_d  = shadow_q;
      pending_d = pending_q;
      done_d    = 1'b0;
      swap      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cnt_d = 16'd0;
            cs_d  = 3'd0;
            swap  = pending_q;
            if (en) state_d = ST_DISPLAY;
         end
         ST_DISPLAY: begin
            if (!en) begin
               state_d = ST_IDLE;
               cnt_d   = 16'd0;
               cs_d    = 3'd0;
            end else if (cnt_q == DIV_LAST) begin
               state_d = ST_BLANK;
               cnt_d   = 16'd0;
            end
         end
         ST_BLANK: begin
            if (!en) begin
               state_d = ST_IDLE;
               cnt_d   = 16'd0;
               cs_d    = 3'd0;
            end else if (cnt_q == BLANK_LAST) begin
               state_d = ST_DISPLAY;
               cnt_d   = 16'd0;
               cs_d    = cs_q + 3'd1;
               // Leaving row 7 closes the frame: the only point a scanning swap may happen
               if (cs_q == 3'd7) begin
                  done_d = 1'b1;
                  swap   = pending_q;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 16'd0;
            cs_d    = 3'd0;
         end
      endcase

      if (swap) begin
         frame_d   = shadow_q;
         pending_d = 1'b0;
      end
      // A load coinciding with a swap lands after the old shadow has been consumed
      if (load) begin
         shadow_d  = d_in;
         pending_d = 1'b1;
      end
      load_ack_d = load;

      row_d   = (state_d == ST_DISPLAY && cnt_d != 16'd0) ? (8'd1 << cs_d) : 8'd0;
      blank_d = (row_d == 8'd0);
   end

   assign load_ack   = load_ack_q;
   assign frame      = frame_q;
   assign cs         = cs_q;
   assign row        = row_q;
   assign blank      = blank_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_dot_scan_ctrl.sv
// tb/tb_dot_scan_ctrl.sv - directed self-checking bench for dot_scan_ctrl
// u1 runs DIV=4/BLANK=2 (6-cycle rows, 48-cycle frames); u2 runs the DIV=2/BLANK=1 corner.

module tb_dot_scan_ctrl;

   logic        clk;
   logic        rst_n;
   logic        en1, en2;
   logic        load;
   logic [63:0] d_in;

   logic        ack1, blank1, done1;
   logic [63:0] frame1;
   logic [2:0]  cs1;
   logic [7:0]  row1;
   logic        ack2, blank2, done2;
   logic [63:0] frame2;
   logic [2:0]  cs2;
   logic [7:0]  row2;

   int errors = 0;
   int checks = 0;

   int          ph;
   bit          bnd;
   bit          ack_e;
   bit          pend_m;
   logic [63:0] exp_frame;
   logic [63:0] sh_m;

   localparam logic [63:0] PAT   = 64'h8040201008040201;
   localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] VAL_A = 64'hA5A5_0000_1234_5678;
   localparam logic [63:0] VAL_B = 64'h0F0F_F0F0_CAFE_BABE;
   localparam logic [63:0] VAL_C = 64'h1111_2222_3333_4444;
   localparam logic [63:0] VAL_D = 64'hDEAD_BEEF_0BAD_F00D;
   localparam logic [63:0] VAL_E = 64'h0102_0304_0506_0708;
   localparam logic [63:0] VAL_F = 64'h7777_7777_7777_7777;

   dot_scan_ctrl #(.DIV(4), .BLANK(2)) u1 (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en1),
      .load       (load),
      .d_in       (d_in),
      .load_ack   (ack1),
      .frame      (frame1),
      .cs         (cs1),
      .row        (row1),
      .blank      (blank1),
      .frame_done (done1)
   );

   dot_scan_ctrl #(.DIV(2), .BLANK(1)) u2 (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en2),
      .load       (load),
      .d_in       (d_in),
      .load_ack   (ack2),
      .frame      (frame2),
      .cs         (cs2),
      .row        (row2),
      .blank      (blank2),
      .frame_done (done2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      ack_e = load;
      @(posedge clk);
      #1;
   endtask

   // One u1 scan cycle: check outputs against the phase within the 48-cycle frame, then advance
   task automatic step();
      logic [2:0] ecs;
      logic [7:0] er;
      int         c;
      bit         swap_now;
      ecs = 3'(ph / 6);
      c   = ph % 6;
      er  = (c >= 1 && c <= 3) ? (8'd1 << ecs) : 8'd0;
      check("row", 64'(row1), 64'(er));
      check("cs", 64'(cs1), 64'(ecs));
      check("blank", 64'(blank1), 64'(er == 8'd0));
      check("frame_done", 64'(done1), 64'(bnd));
      check("load_ack", 64'(ack1), 64'(ack_e));
      check("frame", frame1, exp_frame);
      swap_now = (ph == 47) && pend_m;
      tick();
      if (swap_now) begin
         exp_frame = sh_m;
         pend_m    = 1'b0;
      end
      if (ack_e) begin
         sh_m   = d_in;
         pend_m = 1'b1;
      end
      load = 1'b0;
      ph   = (ph + 1) % 48;
      bnd  = (ph == 0);
   endtask

   task automatic do_load(input logic [63:0] v);
      load = 1'b1;
      d_in = v;
      step();
   endtask

   initial begin
      rst_n = 1'b0; en1 = 1'b0; en2 = 1'b0; load = 1'b0; d_in = 64'd0;
      ph = 0; bnd = 1'b0; ack_e = 1'b0; pend_m = 1'b0; exp_frame = 64'd0; sh_m = 64'd0;

      // Reset state
      tick(); tick();
      check("rst_row", 64'(row1), 64'd0);
      check("rst_cs", 64'(cs1), 64'd0);
      check("rst_frame", frame1, 64'd0);
      check("rst_blank", 64'(blank1), 64'd1);
      check("rst_done", 64'(done1), 64'd0);
      check("rst_ack", 64'(ack1), 64'd0);
      rst_n = 1'b1;
      tick(); tick(); tick();
      check("idle_row", 64'(row1), 64'd0);
      check("idle_cs", 64'(cs1), 64'd0);

      // Basic scan: load in IDLE, swap happens while idle, then enable
      load = 1'b1; d_in = PAT;
      tick();
      check("ack_pulse", 64'(ack1), 64'd1);
      load = 1'b0;
      tick();
      check("ack_clear", 64'(ack1), 64'd0);
      check("idle_swap", frame1, PAT);
      exp_frame = PAT;
      en1 = 1'b1;
      tick();
      ph = 0; bnd = 1'b0;
      repeat (48) step();

      // Deferred swap: load during row 3, visible only at the boundary
      repeat (18) step();
      do_load(ONES);
      repeat (29) step();
      check("deferred_swap", frame1, ONES);
      repeat (48) step();

      // Load A in row 5, load B in the frame_done cycle
      repeat (30) step();
      do_load(VAL_A);
      repeat (17) step();
      check("swap_A", frame1, VAL_A);
      check("swap_A_done", 64'(done1), 64'd1);
      do_load(VAL_B);
      repeat (47) step();
      check("swap_B", frame1, VAL_B);

      // Load sampled on the swap edge itself: swap takes the older shadow
      repeat (10) step();
      do_load(VAL_D);
      repeat (36) step();
      do_load(VAL_C);
      check("swap_old_shadow", frame1, VAL_D);
      repeat (48) step();
      check("swap_new_shadow", frame1, VAL_C);

      // en drop during BLANK of row 6 with a swap pending
      repeat (39) step();
      do_load(VAL_E);
      en1 = 1'b0;
      tick();
      check("drop_row", 64'(row1), 64'd0);
      check("drop_cs", 64'(cs1), 64'd0);
      check("drop_blank", 64'(blank1), 64'd1);
      check("drop_done", 64'(done1), 64'd0);
      check("drop_frame_held", frame1, VAL_C);
      tick();
      check("drop_idle_swap", frame1, VAL_E);
      exp_frame = VAL_E; pend_m = 1'b0;
      tick();
      check("drop_idle_row", 64'(row1), 64'd0);
      en1 = 1'b1;
      tick();
      ph = 0; bnd = 1'b0;
      repeat (14) step();

      // Asynchronous reset mid-row with a load pending
      do_load(VAL_F);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_row", 64'(row1), 64'd0);
      check("async_cs", 64'(cs1), 64'd0);
      check("async_frame", frame1, 64'd0);
      check("async_blank", 64'(blank1), 64'd1);
      check("async_ack", 64'(ack1), 64'd0);
      en1 = 1'b0;
      tick();
      rst_n = 1'b1;
      tick(); tick(); tick();
      check("post_rst_row", 64'(row1), 64'd0);
      check("post_rst_cs", 64'(cs1), 64'd0);
      check("post_rst_frame", frame1, 64'd0);

      // Corner DIV=2, BLANK=1: 3-cycle rows, 24-cycle frames
      check("u2_frame", frame2, 64'd0);
      en2 = 1'b1;
      tick();
      for (int i = 0; i < 50; i++) begin
         int         p;
         logic [2:0] ecs2;
         logic [7:0] er2;
         p    = i % 24;
         ecs2 = 3'(p / 3);
         er2  = (p % 3 == 1) ? (8'd1 << ecs2) : 8'd0;
         check("u2_row", 64'(row2), 64'(er2));
         check("u2_cs", 64'(cs2), 64'(ecs2));
         check("u2_blank", 64'(blank2), 64'(er2 == 8'd0));
         check("u2_done", 64'(done2), 64'(i > 0 && p == 0));
         check("u2_ack", 64'(ack2), 64'd0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
